// File: rtl/npu_core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : npu_core (package)
// Brief    : Shared NPU core definitions: output-AGU FSM encoding and the
//            IOB buffer-select bit index.
// Revision : 1.0 - initial release
// ============================================================================
package npu_core;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } oagu_state_t;

    localparam int BSEL_BIT = 12;

endpackage
`default_nettype wire

// File: rtl/oagu_wport_sel.sv
`default_nettype none
// ============================================================================
// Module   : oagu_wport_sel
// Brief    : Steers one registered write onto the IOB0 or IOB1 port; the
//            unselected port's enable and address are held at zero.
// Revision : 1.0 - initial release
// ============================================================================
module oagu_wport_sel #(
    parameter int AW = 12
) (
    input  logic          i_wen,
    input  logic          i_bsel,
    input  logic [AW-1:0] i_waddr,
    output logic          o_wen0,
    output logic [AW-1:0] o_waddr0,
    output logic          o_wen1,
    output logic [AW-1:0] o_waddr1
);

    assign o_wen0   = i_wen & ~i_bsel;
    assign o_wen1   = i_wen &  i_bsel;
    assign o_waddr0 = o_wen0 ? i_waddr : '0;
    assign o_waddr1 = o_wen1 ? i_waddr : '0;

endmodule
`default_nettype wire

// File: rtl/oagu_dotacc.sv
`default_nettype none
// ============================================================================
// Module   : oagu_dotacc
// Brief    : Output AGU writing PE dot-accumulation results into IOB0/IOB1.
//            Optional sticky drop flag o_ovf_err under OAGU_DOTACC_OVF_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module oagu_dotacc
    import npu_core::*;
#(
    parameter int DW = 16,
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [15:0]   i_StartAdder,
    input  logic [7:0]    i_Out_Count,
    input  logic          i_AGUStart,
    input  logic          i_PE_DOTACC_valid,
    input  logic [DW-1:0] i_PE_DOTACC_data,
    output logic          o_IOB_WEn,
    output logic [AW-1:0] o_IOB_WAddr,
    output logic          o_IOB_WEn1,
    output logic [AW-1:0] o_IOB_WAddr1,
    output logic [DW-1:0] o_IOB_WData,
`ifdef OAGU_DOTACC_OVF_CHK_EN
    output logic          o_ovf_err,
`endif
    output logic          o_busy,
    output logic          o_AGU_Done
);

    oagu_state_t   r_state;
    logic [AW-1:0] r_offset;
    logic          r_bsel;
    logic [7:0]    r_count;
    logic [7:0]    r_idx;
    logic          r_wen;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic          r_busy;
    logic          r_done;
    logic          w_last;
    logic          w_unused_start;

    // Only the offset field and the buffer-select bit are meaningful.
    assign w_unused_start = ^i_StartAdder;
    assign w_last         = (r_idx + 8'd1) == r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_offset <= '0;
            r_bsel   <= 1'b0;
            r_count  <= '0;
            r_idx    <= '0;
            r_wen    <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_wen  <= 1'b0;
            r_done <= 1'b0;
            if (i_AGUStart) begin
                // A start always (re)loads the job, aborting anything in flight.
                r_offset <= i_StartAdder[AW-1:0];
                r_bsel   <= i_StartAdder[BSEL_BIT];
                r_count  <= i_Out_Count;
                r_idx    <= '0;
                r_busy   <= 1'b1;
                if (i_Out_Count != 8'd0) begin
                    r_state <= ST_RUN;
                end else begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (i_PE_DOTACC_valid) begin
                            r_wen   <= 1'b1;
                            r_waddr <= r_offset + AW'(r_idx);
                            r_wdata <= i_PE_DOTACC_data;
                            r_idx   <= r_idx + 8'd1;
                            if (w_last) begin
                                r_state <= ST_DONE;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef OAGU_DOTACC_OVF_CHK_EN
    logic r_ovf;
    logic w_drop;

    // A dropped valid takes precedence over the clear from a coincident start.
    assign w_drop = i_PE_DOTACC_valid & (i_AGUStart | (r_state != ST_RUN));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_AGUStart) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_ovf_err = r_ovf;
`endif

    oagu_wport_sel #(
        .AW (AW)
    ) u_wport_sel (
        .i_wen    (r_wen),
        .i_bsel   (r_bsel),
        .i_waddr  (r_waddr),
        .o_wen0   (o_IOB_WEn),
        .o_waddr0 (o_IOB_WAddr),
        .o_wen1   (o_IOB_WEn1),
        .o_waddr1 (o_IOB_WAddr1)
    );

    assign o_IOB_WData = r_wdata;
    assign o_busy      = r_busy;
    assign o_AGU_Done  = r_done;

endmodule
`default_nettype wire

// File: doc/oagu_dotacc.md
OAGU_DOTACC -- requirements
Module: oagu_dotacc

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning the width of one dot-accumulation result word.
REQ-002 The block SHALL have parameter AW, default 12, meaning the per-buffer IOB write address width.
REQ-003 i_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst  in  1  reset, synchronous and active-high.
REQ-005 i_StartAdder  in  16  first write address; bit 12 selects the buffer (0 = IOB0, 1 = IOB1); bits [11:0] are the offset.
REQ-006 i_Out_Count  in  8  number of results to write for this job.
REQ-007 i_AGUStart  in  1  one-cycle job start pulse.
REQ-008 i_PE_DOTACC_valid  in  1  PE result strobe, the write-side counterpart of the read AGU's DOTACC-out pulse.
REQ-009 i_PE_DOTACC_data  in  DW  result word, qualified by i_PE_DOTACC_valid.
REQ-010 o_IOB_WEn / o_IOB_WAddr  out  1 / AW  IOB0 write enable and address.
REQ-011 o_IOB_WEn1 / o_IOB_WAddr1  out  1 / AW  IOB1 write enable and address.
REQ-012 o_IOB_WData  out  DW  write data, shared by both buffers.
REQ-013 o_busy  out  1  high while a job is active.
REQ-014 o_AGU_Done  out  1  one-cycle job-complete pulse.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 Transition IDLE->RUN: i_AGUStart with i_Out_Count!=0; latch the address, buffer select and count.
REQ-017 Transition IDLE->DONE: i_AGUStart with i_Out_Count==0; no write is issued.
REQ-018 Transition RUN->DONE: the cycle in which the i_Out_Count-th valid is accepted.
REQ-019 DONE SHALL return to IDLE after exactly one cycle.
REQ-020 In RUN, each i_PE_DOTACC_valid SHALL produce exactly one write one cycle later (registered); the address is the latched offset plus the index of that result.
REQ-021 The offset SHALL wrap modulo 2^AW (0xFFF+1 -> 0x000); the buffer select SHALL never change during a job.
REQ-022 Only the WEn of the selected buffer SHALL assert; the other WEn and its address SHALL stay 0.
REQ-023 o_AGU_Done SHALL pulse in the same cycle as the final write; for a zero-count job, it SHALL pulse the cycle after i_AGUStart.
REQ-024 o_busy SHALL be high in RUN and DONE, and low in IDLE.
REQ-025 A valid that arrives in IDLE or DONE, or in the same cycle as i_AGUStart, SHALL be dropped (no write).
REQ-026 An i_AGUStart in RUN or DONE SHALL abort the current job with no done pulse and reload it from the new inputs (same rules as REQ-016/017).
REQ-027 The internal result counter SHALL be 8 bits and never exceed i_Out_Count.

Reset
REQ-028 While i_rst is high, state SHALL be IDLE, counters and addresses 0, and all outputs 0.
REQ-029 A reset asserted mid-job SHALL discard the job with no done pulse; any write registered in that cycle SHALL be suppressed.

Configuration
REQ-030 The macro OAGU_DOTACC_OVF_CHK_EN SHALL control an overflow check.
REQ-031 When the macro is defined, output o_ovf_err (1 bit) SHALL exist; it is a sticky flag set by any valid dropped under REQ-025 and cleared by i_rst or i_AGUStart.
REQ-032 When the macro is undefined, the port and its logic SHALL be absent; drop behaviour is unchanged.

Structure
REQ-033 The FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the buffer-select bit index (12) SHALL live in the shared npu_core package.
REQ-034 The block SHALL be a single module; the write-port mux MAY be a sub-module oagu_wport_sel, but none is required.

Verification
REQ-035 Start 0x0010, count 4, valids on 4 consecutive cycles -> writes to IOB0 at 0x010..0x013 one cycle after each valid; Done coincides with the 0x013 write.
REQ-036 Start 0x1FFE, count 3 -> writes to IOB1 at 0xFFE, 0xFFF, 0x000; IOB0 WEn stays 0 throughout.
REQ-037 Count 0 -> no writes; Done pulses at start+1; busy is high for one cycle.
REQ-038 Start count 5; after 2 valids issue a new start 0x0100 count 2 -> no done for the first job; subsequent writes go to 0x100 and 0x101, then Done.
REQ-039 Valid in IDLE (macro defined) -> no write; o_ovf_err=1 until the next start clears it.
REQ-040 Assert i_rst after 1 of 3 writes -> all outputs 0 next cycle; the remaining valids are ignored.
